// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one 32-bit ALU between two requesters.
// Operands are registered and held at the ALU for EXEC_CYCLES cycles, then the
// result and flags are captured into a response buffer tagged with the requester id.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_command,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_command,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_carryout,
  output logic        rsp_overflow,
  output logic        rsp_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_XOR = 3'd2, C_SLT = 3'd3,
                         C_AND = 3'd4, C_NAND = 3'd5, C_NOR = 3'd6, C_OR = 3'd7;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, rid_q, rid_d;

  logic        grant0, grant1, accept, acc_id;
  logic        sub_op, flag_pass;
  logic [31:0] bx, alu_res;
  logic [32:0] sum;
  logic        alu_cout, alu_ovf;

  // ALU datapath, fed only from the operand registers
  always_comb begin
    sub_op    = (cmd_q == C_SUB) || (cmd_q == C_SLT);
    bx        = sub_op ? ~b_q : b_q;
    sum       = {1'b0, a_q} + {1'b0, bx} + {32'd0, sub_op};
    alu_cout  = sum[32];
    alu_ovf   = (a_q[31] == bx[31]) && (sum[31] != a_q[31]);
    flag_pass = (cmd_q == C_ADD) || (cmd_q == C_SUB) || (cmd_q == C_SLT);
    alu_res   = '0;
    case (cmd_q)
      C_ADD, C_SUB: alu_res = sum[31:0];
      C_XOR:        alu_res = a_q ^ b_q;
      C_SLT:        alu_res = {31'd0, sum[31] ^ alu_ovf};
      C_AND:        alu_res = a_q & b_q;
      C_NAND:       alu_res = ~(a_q & b_q);
      C_NOR:        alu_res = ~(a_q | b_q);
      C_OR:         alu_res = a_q | b_q;
      default:      alu_res = '0;
    endcase
  end

  // Round-robin grant; readys only in IDLE and never during reset
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == IDLE) && !reset && grant0;
    req1_ready = (state_q == IDLE) && !reset && grant1;
    accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    acc_id     = req1_ready;
  end

  // Next-state: accept in IDLE, count down in EXEC, capture on zero, hold in RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    res_d        = res_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    rid_d        = rid_q;
    case (state_q)
      IDLE: if (accept) begin
        cmd_d        = acc_id ? req1_command : req0_command;
        a_d          = acc_id ? req1_a : req0_a;
        b_d          = acc_id ? req1_b : req0_b;
        id_d         = acc_id;
        last_grant_d = acc_id;
        cnt_d        = CNT_INIT;
        state_d      = EXEC;
      end
      EXEC: if (cnt_q == 4'd0) begin
        res_d   = alu_res;
        cout_d  = flag_pass && alu_cout;
        ovf_d   = flag_pass && alu_ovf;
        zero_d  = (alu_res == 32'd0);
        rid_d   = id_q;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      cmd_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      rid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      res_q        <= res_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      rid_q        <= rid_d;
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rid_q;
  assign rsp_result   = res_q;
  assign rsp_carryout = cout_q;
  assign rsp_overflow = ovf_q;
  assign rsp_zero     = zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with immediate-assertion checks.
module tb_alu_arbiter;
  localparam int EC = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req0_command = '0, req1_command = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_overflow, rsp_zero;

  int checks = 0, failures = 0;
  int g[8], cyc[8], n;

  alu_arbiter #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_command(req0_command),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_command(req1_command),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit id, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req1_valid = 1; req1_command = cmd; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_command = cmd; req0_a = a; req0_b = b; end
  endtask

  // Single-requester operation with rsp_ready high; checks latency and response fields
  task automatic run_op(input string tag, input bit id, input logic [2:0] cmd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input bit ec, input bit eo, input bit ez, input bit fl);
    rsp_ready = 1;
    set_req(id, cmd, a, b);
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (EC) begin
      chk({tag, "_early_valid"}, rsp_valid, 0);
      tick();
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_result"}, rsp_result, er);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_zero"}, rsp_zero, ez);
    if (fl) begin
      chk({tag, "_carry"}, rsp_carryout, ec);
      chk({tag, "_ovf"}, rsp_overflow, eo);
    end
    tick();
    chk({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    // Reset state; ready must stay low while reset is high
    req0_valid = 1;
    tick(); tick();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_flags", {rsp_carryout, rsp_overflow, rsp_zero}, 0);
    req0_valid = 0;
    reset = 0;
    tick();

    run_op("add",    0, 3'd0, 32'd5,        32'd7,        32'd12,         0, 0, 0, 1);
    run_op("subovf", 1, 3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000,   0, 1, 0, 1);
    run_op("subz",   1, 3'd1, 32'd3,        32'd3,        32'd0,          1, 0, 1, 1);
    run_op("slt",    0, 3'd3, 32'hFFFFFFFF, 32'd1,        32'd1,          0, 0, 0, 0);
    run_op("or",     1, 3'd7, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0,   0, 0, 0, 1);
    run_op("nand",   0, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,          0, 0, 1, 1);
    run_op("addc",   0, 3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,          1, 0, 1, 1);
    run_op("xormask",1, 3'd2, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE,   0, 0, 0, 1);

    // Contention after reset: grants 0,1,0,1 spaced EC+2 apart
    reset = 1; tick(); reset = 0;
    rsp_ready = 1;
    set_req(0, 3'd0, 32'd1, 32'd1);
    set_req(1, 3'd2, 32'd3, 32'd1);
    #1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      chk("one_ready", {31'd0, req0_ready & req1_ready}, 0);
      if ((req0_ready || req1_ready) && n < 8) begin
        g[n] = req1_ready; cyc[n] = c; n++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", (n >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", g[i], i % 2);
      if (i > 0) chk("rr_spacing", cyc[i] - cyc[i-1], EC + 2);
    end
    repeat (8) tick();

    // Backpressure: response held stable for 10 cycles, readys low
    rsp_ready = 0;
    set_req(0, 3'd4, 32'h000000FF, 32'h0000000F);
    #1;
    chk("bp_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    repeat (EC) tick();
    set_req(0, 3'd0, 32'd5, 32'd7);
    set_req(1, 3'd7, 32'hF0F00000, 32'h0000F0F0);
    #1;
    repeat (10) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 32'h0F);
      chk("bp_id", rsp_id, 0);
      chk("bp_readys", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("hs_valid", rsp_valid, 1);
    chk("hs_readys", {req0_ready, req1_ready}, 0);
    tick();
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_readys", {req0_ready, req1_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (EC) tick();
    chk("bp2_valid", rsp_valid, 1);
    chk("bp2_id", rsp_id, 1);
    chk("bp2_result", rsp_result, 32'hF0F0F0F0);
    tick();

    // Reset during EXEC abandons the operation and restores last_grant
    set_req(0, 3'd0, 32'd5, 32'd7);
    #1;
    chk("rx_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("rx_result", rsp_result, 0);
    repeat (5) begin
      chk("rx_no_rsp", rsp_valid, 0);
      tick();
    end
    set_req(0, 3'd0, 32'd1, 32'd2);
    set_req(1, 3'd0, 32'd3, 32'd4);
    #1;
    chk("rx_grant", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (EC) tick();
    chk("rx2_valid", rsp_valid, 1);
    chk("rx2_result", rsp_result, 32'd3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit gate-level ALU (ADD/SUB/XOR/SLT/AND/NAND/NOR/OR, 3-bit command) between two requesters. It does three things:
- arbitrates round-robin between the requesters;
- registers the winning command and operands and holds them stable at the ALU inputs while its gate delays settle;
- returns the captured result and flags on one buffered response port tagged with the requester id.

It sits between the front-end issue logic and the ALU instance.

## Interface
- EXEC_CYCLES, default 2, number of cycles operands are held at the ALU before capture; legal 1..15.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid.
- req0_command  in  3  ALU command (0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR).
- req0_a, req0_b  in  32  operands A, B.
- req1_valid, req1_ready, req1_command, req1_a, req1_b: same as above, for requester 1.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  32  ALU result.
- rsp_carryout, rsp_overflow, rsp_zero  out  1  flags.

## Operation
- FSM states:
  - IDLE: advances to EXEC on accept.
  - EXEC: advances to RESP when the counter is 0.
  - RESP: advances to IDLE on the rsp_valid & rsp_ready handshake.
- Ready signals: reqN_ready is combinational and high only in IDLE, only for the granted requester, and never while reset is high.
- Grant rule:
  - Only one valid requester: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant, both readys low.
- Accept (valid & ready) in IDLE:
  - Latch command, a, b and id into the operand registers.
  - Set last_grant to id.
  - Load the counter with EXEC_CYCLES-1.
  - Go to EXEC.
- The ALU inputs are driven only from the operand registers. They stay constant from the cycle after accept until the next accept.
- EXEC: the counter decrements each cycle. On the cycle the counter is 0:
  - Capture the ALU result, carryout and overflow into the response registers.
  - Compute rsp_zero = (captured result == 0) locally. The ALU zero output is not used.
  - Go to RESP.
- Flag masking:
  - For XOR/AND/NAND/NOR/OR, rsp_carryout and rsp_overflow are forced to 0.
  - For ADD/SUB/SLT they are passed through as produced.
- RESP:
  - rsp_valid is high.
  - All rsp_* outputs are stable until the handshake.
  - Both reqN_ready are low.
- Only one operation is in flight. No accept happens in RESP, even in the handshake cycle.
- Requester rule (bench-checked, not enforced): command and operands stay stable while valid is high and ready is low.

## Timing
- Reset values:
  - State IDLE, last_grant = 1 (requester 0 wins first contention).
  - rsp_valid 0, rsp_id 0, rsp_result 0, all flags 0.
  - Operand registers 0, counter 0.
- Accept at cycle t. EXEC occupies cycles t+1 .. t+EXEC_CYCLES. rsp_valid is high from cycle t+EXEC_CYCLES+1.
- Handshake at cycle u. rsp_valid is low at u+1 (IDLE), and a new accept is possible at u+1.
- Sustained throughput with rsp_ready held high: one operation per EXEC_CYCLES+2 cycles.
- Simultaneous valids in IDLE: exactly one ready is high. The loser keeps valid and wins the next IDLE grant.
- A requester asserting valid during EXEC/RESP sees ready low until the next IDLE.
- Reset mid-operation, in EXEC or RESP:
  - The next cycle is in reset state and no response is emitted.
  - The abandoned operation is lost.
  - last_grant returns to 1.
- Counter: no wrap. EXEC_CYCLES=1 means EXEC lasts exactly one cycle.

## Test plan
- Reset, then req0 ADD 5+7 with EXEC_CYCLES=2:
  - req0_ready high in the accept cycle t.
  - rsp_valid at t+3 with result 12, id 0, zero 0, carry 0, ovf 0.
- req1 SUB 0x7FFFFFFF - 0xFFFFFFFF → result 0x80000000, overflow 1, id 1. Then SUB 3-3 → result 0, zero 1, carryout 1.
- Both valid continuously, rsp_ready high:
  - Grant order is 0,1,0,1 starting with requester 0 after reset.
  - Accepts are spaced EXEC_CYCLES+2 cycles apart.
- Backpressure: rsp_ready low for 10 cycles in RESP:
  - rsp_* stays unchanged and both readys stay low.
  - After the handshake, the next accept occurs exactly one cycle later.
- SLT 0xFFFFFFFF vs 0x00000001 → result 1. OR 0xF0F00000 | 0x0000F0F0 → 0xF0F0F0F0 with carry 0 and ovf 0. NAND 0xFFFFFFFF,0xFFFFFFFF → 0, zero 1.
- Reset asserted for one cycle during EXEC:
  - rsp_valid stays 0 and no response for that operation appears.
  - With both valid afterwards, requester 0 is granted first.
